// File: rtl/mac_pkg.sv
// Shared widths and vector types for the MAC processing element.
package mac_pkg;

  localparam int MAC_IN_WIDTH_DEFAULT  = 8;
  localparam int MAC_ACC_WIDTH_DEFAULT = 16;

  // Operand and accumulator vectors at the default widths, for PE-array users
  typedef logic [MAC_IN_WIDTH_DEFAULT-1:0]  mac_operand_t;
  typedef logic [MAC_ACC_WIDTH_DEFAULT-1:0] mac_acc_t;

endpackage

// File: rtl/mac_unit.sv
// Registered unsigned multiply-accumulate element: acc_out <= acc_in + a*b.
// The running sum lives outside; acc_in carries it back in. Arithmetic wraps.
module mac_unit
  import mac_pkg::*;
#(
  parameter int IN_WIDTH  = MAC_IN_WIDTH_DEFAULT,
  parameter int ACC_WIDTH = MAC_ACC_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [IN_WIDTH-1:0]  a,
  input  logic [IN_WIDTH-1:0]  b,
  input  logic [ACC_WIDTH-1:0] acc_in,
  output logic [ACC_WIDTH-1:0] acc_out
);

  // Full-precision product, and a sum one bit wider than the widest addend so
  // no carry is lost before the final truncation to ACC_WIDTH.
  localparam int PROD_W = 2 * IN_WIDTH;
  localparam int SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;

  logic [PROD_W-1:0]    prod;
  logic [SUM_W-1:0]     sum;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [ACC_WIDTH-1:0] acc_q;

  // Next accumulator value: new MAC result when enabled, otherwise hold
  always_comb begin
    prod  = PROD_W'(a) * PROD_W'(b);
    sum   = SUM_W'(acc_in) + SUM_W'(prod);
    acc_d = acc_q;
    if (en) acc_d = sum[ACC_WIDTH-1:0];
  end

  // Result register; synchronous active-low reset takes priority over en
  always_ff @(posedge clk) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign acc_out = acc_q;

endmodule

// File: tb/tb_mac_unit.sv
// Directed-vector bench for mac_unit with hand-computed expected values.
module tb_mac_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] acc_in;
  logic [15:0] acc_out;

  int n_tests;
  int n_fail;

  mac_unit #(.IN_WIDTH(8), .ACC_WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .a      (a),
    .b      (b),
    .acc_in (acc_in),
    .acc_out(acc_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  // Drive one vector; it is sampled on the next rising edge
  task automatic drive(input logic r, input logic e, input logic [7:0] va,
                       input logic [7:0] vb, input logic [15:0] vacc);
    rst = r; en = e; a = va; b = vb; acc_in = vacc;
  endtask

  // Advance to the next edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drive(1'b1, 1'b0, 8'd0, 8'd0, 16'd0);
    @(negedge clk);

    drive(1'b0, 1'b0, 8'd10, 8'd20, 16'd100);
    step(); chk("reset", acc_out, 16'd0);

    drive(1'b1, 1'b1, 8'd10, 8'd20, 16'd100);
    step(); chk("basic_mac", acc_out, 16'd300);

    drive(1'b1, 1'b1, 8'd5, 8'd4, 16'd300);
    step(); chk("chained_mac", acc_out, 16'd320);

    // rst pulse entirely between two edges must not be sampled
    drive(1'b1, 1'b0, 8'd15, 8'd10, 16'd320);
    #4 rst = 1'b0;
    #10 rst = 1'b1;
    step(); chk("glitch_hold", acc_out, 16'd320);

    drive(1'b1, 1'b0, 8'hAA, 8'h55, 16'h7777);
    step(); chk("hold_en0", acc_out, 16'd320);

    drive(1'b1, 1'b1, 8'h01, 8'hFF, 16'hFFFF);
    step(); chk("overflow_wrap", acc_out, 16'h00FE);

    drive(1'b0, 1'b1, 8'hFF, 8'hFF, 16'h1234);
    step(); chk("reset_priority", acc_out, 16'h0000);

    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 16'h0000);
    step(); chk("max_product", acc_out, 16'hFE01);

    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 16'h01FF);
    step(); chk("exact_wrap_zero", acc_out, 16'h0000);

    drive(1'b1, 1'b1, 8'h00, 8'h77, 16'hABCD);
    step(); chk("zero_operand", acc_out, 16'hABCD);

    drive(1'b1, 1'b1, 8'h12, 8'h34, 16'h1000);
    step(); chk("mid_values", acc_out, 16'h13A8);

    drive(1'b1, 1'b0, 8'hFF, 8'hFF, 16'hFFFF);
    step(); chk("hold_after_mac", acc_out, 16'h13A8);

    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 16'hFFFF);
    step(); chk("max_all_wrap", acc_out, 16'hFE00);

    drive(1'b1, 1'b1, 8'h80, 8'h80, 16'h0000);
    step(); chk("msb_operands", acc_out, 16'h4000);

    drive(1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
    step(); chk("reset_en0", acc_out, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
